// File: rtl/ser_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state codes, idle line
// level and a helper that maps FSM state to the serial line level.
package ser_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   localparam logic TX_IDLE_LVL = 1'b1;

   // Line level driven while in a given state; data_bit is used only in DATA.
   function automatic logic line_level(input tx_state_e st, input logic data_bit);
      logic lvl;
      case (st)
         ST_START: lvl = ~TX_IDLE_LVL;
         ST_DATA:  lvl = data_bit;
         default:  lvl = TX_IDLE_LVL;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for a level already synchronous to clk_in. Produces a
// one-cycle pulse per rising edge. The history flop resets high so that an
// input already high when reset releases does not produce a spurious pulse.
module tick_edge_det (
   input  logic clk_in,
   input  logic rst_n,
   input  logic sig_in,
   output logic pulse
);

   logic sig_q;

   // Remember last cycle's level of the input.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b1;
      end else begin
         sig_q <= sig_in;
      end
   end

   assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/ser_tx.sv
// UART-style serial transmitter. Words are accepted over valid/ready while
// idle, then shifted out LSB first framed by one start bit and STOP_BITS stop
// bits. Bit timing is derived from rising edges of div_clk (ticks); every
// state change except the accept happens on a tick, and tx_line is
// registered so it moves on the cycle after the tick that ends a bit.
module ser_tx
   import ser_tx_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int TICKS_PER_BIT = 1,
   parameter int STOP_BITS     = 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              div_clk,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_line,
   output logic              tx_busy
);

   // bit_cnt also counts stop bits, so it must hold DATA_W-1 and STOP_BITS-1.
   localparam int BIT_W = $clog2(DATA_W) + 1;
   localparam logic [7:0]       LAST_TICK = 8'(TICKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   tx_state_e         state_q, state_d;
   logic [7:0]        tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              line_q, line_d;
   logic              ready_q;
   logic              busy_q;
   logic              tick_s;
   logic              bit_end_s;

   tick_edge_det u_tick (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig_in (div_clk),
      .pulse  (tick_s)
   );

   // A bit period ends on the tick that completes TICKS_PER_BIT ticks.
   assign bit_end_s = tick_s & (tick_cnt_q == LAST_TICK);

   // Next-state logic: handshake, bit/tick counting and shifting.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_valid && ready_q) begin
               state_d = ST_ARM;
               shift_d = tx_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (tick_s) begin
               state_d    = ST_START;
               tick_cnt_d = 8'd0;
               bit_cnt_d  = {BIT_W{1'b0}};
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d    = ST_DATA;
               tick_cnt_d = 8'd0;
            end else if (tick_s) begin
               tick_cnt_d = tick_cnt_q + 8'd1;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               tick_cnt_d = 8'd0;
               shift_d    = shift_q >> 1'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = ST_STOP;
                  bit_cnt_d = {BIT_W{1'b0}};
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
               end
            end else if (tick_s) begin
               tick_cnt_d = tick_cnt_q + 8'd1;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               tick_cnt_d = 8'd0;
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = {BIT_W{1'b0}};
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
               end
            end else if (tick_s) begin
               tick_cnt_d = tick_cnt_q + 8'd1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tick_cnt_d = 8'd0;
            bit_cnt_d  = {BIT_W{1'b0}};
         end
      endcase
      line_d = line_level(state_d, shift_d[0]);
   end

   // State, datapath and registered outputs; reset forces the idle line at once.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= 8'd0;
         bit_cnt_q  <= {BIT_W{1'b0}};
         shift_q    <= {DATA_W{1'b0}};
         line_q     <= TX_IDLE_LVL;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         line_q     <= line_d;
         ready_q    <= (state_d == ST_IDLE);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign tx_line  = line_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx. Instance dut uses TICKS_PER_BIT=2 (10-cycle
// bits), instance dut2 uses TICKS_PER_BIT=1 with two stop bits. div_clk is
// a 1-in-5 divided clock (2 high, 3 low) that can be frozen low.
module tb_ser_tx;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic       div_clk = 1'b1;
   logic       div_run = 1'b0;
   int         div_cnt = 0;

   logic [7:0] tx_data_a = 8'h00, tx_data_b = 8'h00;
   logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
   logic       tx_ready_a, tx_line_a, tx_busy_a;
   logic       tx_ready_b, tx_line_b, tx_busy_b;

   int         checks = 0;
   int         errors = 0;

   logic       line_s [0:255];
   logic       rdy_s  [0:255];
   logic       bsy_s  [0:255];

   ser_tx #(.DATA_W(8), .TICKS_PER_BIT(2), .STOP_BITS(1)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .div_clk(div_clk),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .tx_line(tx_line_a), .tx_busy(tx_busy_a)
   );

   ser_tx #(.DATA_W(8), .TICKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
      .clk_in(clk_in), .rst_n(rst_n), .div_clk(div_clk),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .tx_line(tx_line_b), .tx_busy(tx_busy_b)
   );

   always #10 clk_in = ~clk_in;

   // Divided clock: period 5 clk_in cycles, high for 2, frozen when div_run=0.
   always @(posedge clk_in) begin
      if (div_run) begin
         if (div_cnt == 4) begin
            div_cnt <= 0;
            div_clk <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 1;
            div_clk <= ((div_cnt + 1) < 2);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic sample(input int idx, input bit sel);
      line_s[idx] = sel ? tx_line_b  : tx_line_a;
      rdy_s[idx]  = sel ? tx_ready_b : tx_ready_a;
      bsy_s[idx]  = sel ? tx_busy_b  : tx_busy_a;
   endtask

   task automatic capture(input int from, input int to, input bit sel);
      for (int i = from; i <= to; i++) begin
         @(negedge clk_in);
         sample(i, sel);
      end
   endtask

   // Waits (bounded) for the start bit; that cycle becomes sample 0.
   task automatic wait_start(input bit sel, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk_in);
         if ((sel ? tx_line_b : tx_line_a) === 1'b0) begin
            ok = 1'b1;
            sample(0, sel);
         end
      end
   endtask

   // Presents a word until accepted, then drops valid and scrambles data.
   task automatic send(input bit sel, input logic [7:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk_in);
      if (sel) begin tx_data_b = d; tx_valid_b = 1'b1; end
      else     begin tx_data_a = d; tx_valid_a = 1'b1; end
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if ((sel ? tx_ready_b : tx_ready_a) === 1'b0) ok = 1'b1;
      end
      if (sel) begin tx_valid_b = 1'b0; tx_data_b = ~d; end
      else     begin tx_valid_a = 1'b0; tx_data_a = ~d; end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
      #1;
      checks++;
      if (dut.tick_s !== 1'b0) begin
         errors++; $display("FAIL reset_tick: got %b want 0", dut.tick_s);
      end
      checks++;
      if ({tx_line_a, tx_ready_a, tx_busy_a} !== 3'b110) begin
         errors++; $display("FAIL reset_outs: line/ready/busy got %b want 110", {tx_line_a, tx_ready_a, tx_busy_a});
      end
      @(negedge clk_in);
      checks++;
      if ({tx_line_b, tx_ready_b, tx_busy_b} !== 3'b110) begin
         errors++; $display("FAIL reset_outs2: line/ready/busy got %b want 110", {tx_line_b, tx_ready_b, tx_busy_b});
      end
      div_run = 1'b1;
      repeat (10) @(negedge clk_in);
   endtask

   task automatic test_frame_a5;
      logic [9:0] exp_v;
      bit ok;
      int bad;
      exp_v = 10'b1101001010;   // 0,1,0,1,0,0,1,0,1,1 from bit 0 upward
      send(1'b0, 8'hA5, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL a5_accept: ready never dropped"); end
      wait_start(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL a5_start: no start bit within budget"); end
      capture(1, 100, 1'b0);
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int j = 0; j < 10; j++) if (line_s[k*10+j] !== exp_v[k]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL a5_bit%0d: %0d of 10 samples differ from level %b", k, bad, exp_v[k]);
         end
      end
      checks++;
      if ({bsy_s[99], bsy_s[100], rdy_s[99], rdy_s[100]} !== 4'b1001) begin
         errors++; $display("FAIL a5_end: busy99/busy100/rdy99/rdy100 got %b want 1001",
                            {bsy_s[99], bsy_s[100], rdy_s[99], rdy_s[100]});
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int bad;
      @(negedge clk_in);
      tx_data_a = 8'h00; tx_valid_a = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if (tx_ready_a === 1'b0) ok = 1'b1;
      end
      tx_data_a = 8'hFF;
      wait_start(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_start: no start bit within budget"); end
      for (int v = 1; v <= 205; v++) begin
         @(negedge clk_in);
         sample(v, 1'b0);
         if (v > 100 && tx_valid_a && tx_ready_a === 1'b0) begin
            tx_valid_a = 1'b0; tx_data_a = 8'h00;
         end
      end
      bad = 0;
      for (int v = 0; v < 90; v++) if (line_s[v] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_frame0: %0d samples not low in start/data", bad); end
      bad = 0;
      for (int v = 90; v < 105; v++) if (line_s[v] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_gap: %0d samples not high in stop/arm", bad); end
      bad = 0;
      for (int v = 105; v < 115; v++) if (line_s[v] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_start2: %0d samples not low in second start", bad); end
      bad = 0;
      for (int v = 115; v < 205; v++) if (line_s[v] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_frame1: %0d samples not high in 0xFF data/stop", bad); end
      checks++;
      if ({rdy_s[100], rdy_s[101], bsy_s[100], bsy_s[101], bsy_s[205]} !== 5'b10010) begin
         errors++; $display("FAIL b2b_handshake: rdy100/rdy101/bsy100/bsy101/bsy205 got %b want 10010",
                            {rdy_s[100], rdy_s[101], bsy_s[100], bsy_s[101], bsy_s[205]});
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [9:0] exp_v;
      bit ok;
      int bad;
      send(1'b0, 8'hF0, ok);
      wait_start(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_start: no start bit within budget"); end
      capture(1, 45, 1'b0);
      checks++;
      if (line_s[45] !== 1'b0) begin errors++; $display("FAIL rst_pre: line got %b want 0", line_s[45]); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_line_a, tx_ready_a, tx_busy_a} !== 3'b110) begin
         errors++; $display("FAIL rst_async: line/ready/busy got %b want 110", {tx_line_a, tx_ready_a, tx_busy_a});
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      exp_v = 10'b1001111000;   // 0x3C framed
      send(1'b0, 8'h3C, ok);
      wait_start(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_3c_start: no start bit within budget"); end
      capture(1, 100, 1'b0);
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int j = 0; j < 10; j++) if (line_s[k*10+j] !== exp_v[k]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL 3c_bit%0d: %0d of 10 samples differ from level %b", k, bad, exp_v[k]);
         end
      end
   endtask

   task automatic test_div_stall;
      logic [9:0] exp_v;
      bit ok;
      int bad;
      exp_v = 10'b1100101100;   // 0x96 framed
      send(1'b0, 8'h96, ok);
      wait_start(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_start: no start bit within budget"); end
      for (int v = 1; v <= 100; v++) begin
         @(negedge clk_in);
         sample(v, 1'b0);
         if (v == 46) begin
            div_run = 1'b0;
            bad = 0;
            repeat (100) begin
               @(negedge clk_in);
               if (tx_line_a !== exp_v[4]) bad++;
            end
            checks++;
            if (bad != 0) begin
               errors++; $display("FAIL stall_hold: %0d of 100 samples differ from level %b", bad, exp_v[4]);
            end
            div_run = 1'b1;
         end
      end
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int j = 0; j < 10; j++) if (line_s[k*10+j] !== exp_v[k]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL 96_bit%0d: %0d of 10 samples differ from level %b", k, bad, exp_v[k]);
         end
      end
      checks++;
      if ({bsy_s[99], bsy_s[100]} !== 2'b10) begin
         errors++; $display("FAIL stall_end: busy99/busy100 got %b want 10", {bsy_s[99], bsy_s[100]});
      end
   endtask

   task automatic test_two_stop;
      logic [9:0] exp_v;
      bit ok;
      int bad;
      exp_v = 10'b1100000010;   // 0x81 framed
      send(1'b1, 8'h81, ok);
      wait_start(1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stop2_start: no start bit within budget"); end
      capture(1, 55, 1'b1);
      for (int k = 0; k < 9; k++) begin
         bad = 0;
         for (int j = 0; j < 5; j++) if (line_s[k*5+j] !== exp_v[k]) bad++;
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL 81_bit%0d: %0d of 5 samples differ from level %b", k, bad, exp_v[k]);
         end
      end
      bad = 0;
      for (int v = 45; v < 55; v++) if (line_s[v] !== 1'b1 || rdy_s[v] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stop2_len: %0d stop samples not high with ready low", bad); end
      checks++;
      if ({rdy_s[55], bsy_s[54], bsy_s[55]} !== 3'b110) begin
         errors++; $display("FAIL stop2_end: rdy55/bsy54/bsy55 got %b want 110", {rdy_s[55], bsy_s[54], bsy_s[55]});
      end
   endtask

   initial begin
      test_reset;
      test_frame_a5;
      test_back_to_back;
      test_reset_mid_frame;
      test_div_stall;
      test_two_stop;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
